// File: rtl/bullet_pkg.sv
// Shared types and playfield constants for the bullet scheduler
// and the bullet instances it feeds.
package bullet_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int LAUNCH_Y = 240;

  function automatic logic [3:0] popcount8(
    input logic [7:0] v
  );
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++)
      c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/rr_free_finder.sv
// Round-robin free-slot search: first idle slot at or after rr_ptr,
// wrapping modulo NUM_SLOTS.
module rr_free_finder
  import bullet_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int IW        = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic [IW-1:0]        rr_ptr,
  output logic                 found,
  output logic [IW-1:0]        index
);

  int j;

  // Walk from the far end back so the closest candidate wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_SLOTS)
        j = j - NUM_SLOTS;
      if (!slot_busy[IW'(j)]) begin
        found = 1'b1;
        index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bullet_scheduler.sv
// Fire-request scheduler: edge detect, cooldown, round-robin slot
// allocation, launch strobe and busy-flag acknowledgement.
module bullet_scheduler
  import bullet_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int COOLDOWN_FRAMES = 10,
  parameter int ACK_TIMEOUT     = 3
) (
  input  logic                 clk_60hz,
  input  logic                 reset_n,
  input  logic                 fire,
  input  logic [9:0]           ship_x,
  input  logic                 direction,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  output logic [NUM_SLOTS-1:0] start_bullet,
  output logic [9:0]           launch_x,
  output logic                 launch_dir,
  output logic [3:0]           active_count,
  output logic [7:0]           dropped_count,
  output logic                 launch_fault,
  output logic                 ready
);

  localparam int IW = $clog2(NUM_SLOTS);

  localparam logic [NUM_SLOTS-1:0] ONE =
    {{(NUM_SLOTS-1){1'b0}}, 1'b1};

  state_e        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] slot;
  logic [IW-1:0] free_idx;
  logic          free_found;
  logic          pending;
  logic          fire_q;
  logic [7:0]    cd;
  logic [3:0]    to_cnt;
  logic          fire_edge;
  logic          trigger;

  assign fire_edge = fire & ~fire_q;
  assign trigger   = fire_edge | pending;
  assign ready     = (state == IDLE);

  rr_free_finder #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_finder (
    .slot_busy (slot_busy),
    .rr_ptr    (rr_ptr),
    .found     (free_found),
    .index     (free_idx)
  );

  always_ff @(posedge clk_60hz or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      slot          <= '0;
      pending       <= 1'b0;
      fire_q        <= 1'b0;
      cd            <= '0;
      to_cnt        <= '0;
      start_bullet  <= '0;
      launch_x      <= '0;
      launch_dir    <= 1'b0;
      active_count  <= '0;
      dropped_count <= '0;
      launch_fault  <= 1'b0;
    end else begin
      fire_q       <= fire;
      active_count <= popcount8(8'(slot_busy));
      start_bullet <= '0;
      // One-deep queue: later edges while busy are lost.
      if (fire_edge && state != IDLE)
        pending <= 1'b1;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            pending <= 1'b0;
            if (free_found) begin
              slot         <= free_idx;
              launch_x     <= ship_x;
              launch_dir   <= direction;
              start_bullet <= ONE << free_idx;
              state        <= LAUNCH;
            end else if (dropped_count != 8'hFF) begin
              dropped_count <= dropped_count + 8'd1;
            end
          end
        end
        LAUNCH: begin
          to_cnt <= '0;
          state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (slot_busy[slot]) begin
            cd    <= 8'(COOLDOWN_FRAMES);
            state <= COOLDOWN;
            if (slot == IW'(NUM_SLOTS - 1))
              rr_ptr <= '0;
            else
              rr_ptr <= slot + 1'b1;
          end else begin
            to_cnt <= to_cnt + 4'd1;
            if (to_cnt + 4'd1 == 4'(ACK_TIMEOUT)) begin
              launch_fault <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        COOLDOWN: begin
          if (cd == 8'd0)
            state <= IDLE;
          else
            cd <= cd - 8'd1;
        end
      endcase
    end
  end

endmodule
